// File: rtl/color_centroid_tracker.sv
// color_centroid_tracker: fetches a 16x16 RGB frame, counts the pixels within a
// per-channel tolerance of a target colour, and reports the integer centroid of the
// matches. Latency from o_fetch to o_valid is a fixed 262 cycles.
module color_centroid_tracker #(
    parameter int unsigned TOL       = 16,
    parameter int unsigned MIN_COUNT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [9:0]  i_tR,
    input  logic [9:0]  i_tG,
    input  logic [9:0]  i_tB,
    input  logic        i_oktofetch,
    output logic        o_fetch,
    input  logic [9:0]  i_buf [0:2][0:15][0:15],
    output logic        o_valid,
    output logic        o_found,
    output logic [8:0]  o_count,
    output logic [3:0]  o_x,
    output logic [3:0]  o_y
);

    localparam int unsigned PIX_W = 10;
    localparam int unsigned CNT_W = 9;
    localparam int unsigned SUM_W = 12;
    localparam int unsigned CRD_W = 4;
    localparam int unsigned IDX_W = 8;
    localparam int unsigned DSH_W = CNT_W + CRD_W;
    localparam int unsigned DIV_W = 2;

    localparam logic [PIX_W-1:0] TOL_V = PIX_W'(TOL);
    localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_COUNT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(3);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SCAN,
        ST_DIV,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PIX_W-1:0]   tr_q, tr_d, tg_q, tg_d, tb_q, tb_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic [SUM_W-1:0]   sumx_q, sumx_d, sumy_q, sumy_d;
    logic [CRD_W-1:0]   qx_q, qx_d, qy_q, qy_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;

    logic               fetch_q, fetch_d;
    logic               valid_q, valid_d;
    logic               found_q, found_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CRD_W-1:0]   x_q, x_d, y_q, y_d;

    logic [CRD_W-1:0]   row_c, col_c;
    logic [PIX_W-1:0]   pix_r_c, pix_g_c, pix_b_c;
    logic               match_c;
    logic [DIV_W-1:0]   shamt_c;
    logic [DSH_W-1:0]   dsh_c;
    logic               bx_c, by_c;
    logic               found_c;

    // Unsigned absolute difference of two pixel values.
    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Current pixel under the scan index and its match against the latched target.
    always_comb begin
        row_c   = idx_q[7:4];
        col_c   = idx_q[3:0];
        pix_r_c = i_buf[0][row_c][col_c];
        pix_g_c = i_buf[1][row_c][col_c];
        pix_b_c = i_buf[2][row_c][col_c];
        match_c = (abs_diff(pix_r_c, tr_q) <= TOL_V) &&
                  (abs_diff(pix_g_c, tg_q) <= TOL_V) &&
                  (abs_diff(pix_b_c, tb_q) <= TOL_V);
    end

    // One restoring-division step for both centroid axes; a zero count yields zero bits.
    always_comb begin
        shamt_c = DIV_LAST - div_cnt_q;
        dsh_c   = DSH_W'(acc_cnt_q) << shamt_c;
        bx_c    = (acc_cnt_q != '0) && (DSH_W'(sumx_q) >= dsh_c);
        by_c    = (acc_cnt_q != '0) && (DSH_W'(sumy_q) >= dsh_c);
        found_c = (acc_cnt_q >= MIN_V);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        tr_d      = tr_q;
        tg_d      = tg_q;
        tb_d      = tb_q;
        idx_d     = idx_q;
        acc_cnt_d = acc_cnt_q;
        sumx_d    = sumx_q;
        sumy_d    = sumy_q;
        qx_d      = qx_q;
        qy_d      = qy_q;
        div_cnt_d = div_cnt_q;
        fetch_d   = 1'b0;
        valid_d   = 1'b0;
        found_d   = found_q;
        count_d   = count_q;
        x_d       = x_q;
        y_d       = y_q;

        case (state_q)
            ST_IDLE: begin
                if (i_enable && i_oktofetch) begin
                    state_d = ST_REQ;
                    fetch_d = 1'b1;
                end
            end
            ST_REQ: begin
                tr_d    = i_tR;
                tg_d    = i_tG;
                tb_d    = i_tB;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                idx_d     = '0;
                acc_cnt_d = '0;
                sumx_d    = '0;
                sumy_d    = '0;
                state_d   = ST_SCAN;
            end
            ST_SCAN: begin
                if (match_c) begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    sumx_d    = sumx_q + SUM_W'(col_c);
                    sumy_d    = sumy_q + SUM_W'(row_c);
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == '1) begin
                    div_cnt_d = '0;
                    qx_d      = '0;
                    qy_d      = '0;
                    state_d   = ST_DIV;
                end
            end
            ST_DIV: begin
                if (bx_c) sumx_d = sumx_q - SUM_W'(dsh_c);
                if (by_c) sumy_d = sumy_q - SUM_W'(dsh_c);
                qx_d      = {qx_q[CRD_W-2:0], bx_c};
                qy_d      = {qy_q[CRD_W-2:0], by_c};
                div_cnt_d = div_cnt_q + DIV_W'(1);
                if (div_cnt_q == DIV_LAST) begin
                    valid_d = 1'b1;
                    count_d = acc_cnt_q;
                    found_d = found_c;
                    x_d     = found_c ? qx_d : '0;
                    y_d     = found_c ? qy_d : '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            tr_q      <= '0;
            tg_q      <= '0;
            tb_q      <= '0;
            idx_q     <= '0;
            acc_cnt_q <= '0;
            sumx_q    <= '0;
            sumy_q    <= '0;
            qx_q      <= '0;
            qy_q      <= '0;
            div_cnt_q <= '0;
            fetch_q   <= 1'b0;
            valid_q   <= 1'b0;
            found_q   <= 1'b0;
            count_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            state_q   <= state_d;
            tr_q      <= tr_d;
            tg_q      <= tg_d;
            tb_q      <= tb_d;
            idx_q     <= idx_d;
            acc_cnt_q <= acc_cnt_d;
            sumx_q    <= sumx_d;
            sumy_q    <= sumy_d;
            qx_q      <= qx_d;
            qy_q      <= qy_d;
            div_cnt_q <= div_cnt_d;
            fetch_q   <= fetch_d;
            valid_q   <= valid_d;
            found_q   <= found_d;
            count_q   <= count_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    assign o_fetch = fetch_q;
    assign o_valid = valid_q;
    assign o_found = found_q;
    assign o_count = count_q;
    assign o_x     = x_q;
    assign o_y     = y_q;

endmodule

// File: tb/tb_color_centroid_tracker.sv
// Testbench for color_centroid_tracker: scenario frames with a scoreboard of expected
// results, fixed-latency checks, back-to-back fetching and reset abort.
module tb_color_centroid_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ok;
    logic [9:0] t_r, t_g, t_b;
    logic [9:0] frame [0:2][0:15][0:15];
    logic       o_fetch, o_valid, o_found;
    logic [8:0] o_count;
    logic [3:0] o_x, o_y;

    always #5 clk = ~clk;

    color_centroid_tracker dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enable    (en),
        .i_tR        (t_r),
        .i_tG        (t_g),
        .i_tB        (t_b),
        .i_oktofetch (ok),
        .o_fetch     (o_fetch),
        .i_buf       (frame),
        .o_valid     (o_valid),
        .o_found     (o_found),
        .o_count     (o_count),
        .o_x         (o_x),
        .o_y         (o_y)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cnt;
        bit found;
        int x;
        int y;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic exp_t mk(input int c, input bit f, input int x, input int y);
        exp_t e;
        e.cnt = c; e.found = f; e.x = x; e.y = y;
        return e;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Behavioural reference: scan the bench frame against a target.
    function automatic exp_t model(input int r, input int g, input int b);
        int c, sx, sy;
        exp_t e;
        c = 0; sx = 0; sy = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                if (iabs(int'(frame[0][y][x]) - r) <= 16 &&
                    iabs(int'(frame[1][y][x]) - g) <= 16 &&
                    iabs(int'(frame[2][y][x]) - b) <= 16) begin
                    c++; sx += x; sy += y;
                end
        e.cnt = c;
        e.found = (c >= 4);
        e.x = e.found ? sx / c : 0;
        e.y = e.found ? sy / c : 0;
        return e;
    endfunction

    task automatic fill(input int r, input int g, input int b);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                frame[0][y][x] = 10'(r);
                frame[1][y][x] = 10'(g);
                frame[2][y][x] = 10'(b);
            end
    endtask

    task automatic set_px(input int y, input int x, input int r, input int g, input int b);
        frame[0][y][x] = 10'(r);
        frame[1][y][x] = 10'(g);
        frame[2][y][x] = 10'(b);
    endtask

    task automatic set_target(input int r, input int g, input int b);
        t_r = 10'(r); t_g = 10'(g); t_b = 10'(b);
    endtask

    task automatic wait_fetch(output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_fetch === 1'b1) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic wait_valid(output int t, output int nf);
        t = -1; nf = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (o_fetch === 1'b1) nf++;
            if (o_valid === 1'b1) begin
                t = cyc;
                break;
            end
        end
    endtask

    // Load a scenario frame and target, and push its expected result.
    task automatic setup_scenario(input int s);
        int v;
        case (s)
            0: begin
                fill(100, 100, 100); set_target(100, 100, 100);
                sb.push_back(mk(256, 1'b1, 7, 7));
            end
            1: begin
                fill(0, 0, 0); set_target(300, 600, 900);
                set_px(4, 10, 300, 600, 900); set_px(4, 11, 300, 600, 900);
                set_px(5, 10, 300, 600, 900); set_px(5, 11, 300, 600, 900);
                sb.push_back(mk(4, 1'b1, 10, 4));
            end
            2: begin
                fill(0, 0, 0); set_target(300, 600, 900);
                set_px(3, 12, 300, 600, 900);
                sb.push_back(mk(1, 1'b0, 0, 0));
            end
            3: begin
                fill(0, 0, 0); set_target(500, 500, 500);
                set_px(2, 5, 516, 500, 500); set_px(9, 1, 517, 500, 500);
                sb.push_back(mk(1, 1'b0, 0, 0));
            end
            4: begin
                fill(0, 0, 0); set_target(1000, 1000, 1000);
                sb.push_back(mk(0, 1'b0, 0, 0));
            end
            5: begin
                fill(0, 0, 0); set_target(500, 500, 500);
                set_px(15, 15, 500, 484, 500); set_px(15, 14, 500, 500, 500);
                set_px(14, 15, 500, 500, 500); set_px(14, 14, 500, 500, 500);
                set_px(0, 0, 500, 500, 483);
                sb.push_back(mk(4, 1'b1, 14, 14));
            end
            default: begin
                set_target(500, 400, 300);
                for (int y = 0; y < 16; y++)
                    for (int x = 0; x < 16; x++) begin
                        v = 500 + int'($urandom_range(48, 0)) - 24; frame[0][y][x] = 10'(v);
                        v = 400 + int'($urandom_range(48, 0)) - 24; frame[1][y][x] = 10'(v);
                        v = 300 + int'($urandom_range(48, 0)) - 24; frame[2][y][x] = 10'(v);
                    end
                sb.push_back(model(500, 400, 300));
            end
        endcase
    endtask

    task automatic test_reset;
        int nf;
        rst = 1'b1; en = 1'b0; ok = 1'b0;
        set_target(0, 0, 0);
        fill(0, 0, 0);
        repeat (3) @(negedge clk);
        n_total++;
        if ({o_fetch, o_valid, o_found, o_count, o_x, o_y} !== 20'd0) begin
            $display("FAIL reset_outputs: got fetch=%b valid=%b found=%b count=%0d x=%0d y=%0d, want all 0",
                     o_fetch, o_valid, o_found, o_count, o_x, o_y);
        end else n_pass++;
        rst = 1'b0;
        ok = 1'b1;
        nf = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_fetch === 1'b1) nf++;
        end
        n_total++;
        if (nf !== 0) $display("FAIL idle_disabled_fetch: got %0d fetch pulses, want 0", nf);
        else n_pass++;
    endtask

    task automatic test_patterns;
        int tf, tv, nf;
        exp_t e;
        for (int s = 0; s < 7; s++) begin
            setup_scenario(s);
            en = 1'b1; ok = 1'b1;
            wait_fetch(tf);
            @(negedge clk);
            // Target and fetch controls change after REQ; the frame in flight must ignore them.
            t_r = 10'($urandom); t_g = 10'($urandom); t_b = 10'($urandom);
            en = 1'b0; ok = 1'b0;
            wait_valid(tv, nf);
            e = sb.pop_front();
            n_total++;
            if (tf < 0 || tv < 0 || tv - tf != 262)
                $display("FAIL latency_s%0d: got fetch@%0d valid@%0d, want valid 262 cycles after fetch", s, tf, tv);
            else n_pass++;
            n_total++;
            if (o_count !== 9'(e.cnt) || o_found !== e.found || o_x !== 4'(e.x) || o_y !== 4'(e.y))
                $display("FAIL result_s%0d: got count=%0d found=%b x=%0d y=%0d, want count=%0d found=%b x=%0d y=%0d",
                         s, o_count, o_found, o_x, o_y, e.cnt, e.found, e.x, e.y);
            else n_pass++;
            @(negedge clk);
            n_total++;
            if (o_valid !== 1'b0 || o_fetch !== 1'b0 || o_count !== 9'(e.cnt) || o_x !== 4'(e.x) || o_y !== 4'(e.y))
                $display("FAIL hold_s%0d: got valid=%b fetch=%b count=%0d x=%0d y=%0d, want valid=0 fetch=0 count=%0d x=%0d y=%0d",
                         s, o_valid, o_fetch, o_count, o_x, o_y, e.cnt, e.x, e.y);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        int tf1, tv1, nf1, tf2, tv2, nf2, nf3;
        exp_t e;
        setup_scenario(0);
        setup_scenario(0);
        en = 1'b1; ok = 1'b1;
        wait_fetch(tf1);
        wait_valid(tv1, nf1);
        n_total++;
        if (tf1 < 0 || tv1 < 0 || tv1 - tf1 != 262 || nf1 != 0)
            $display("FAIL b2b_first: got fetch@%0d valid@%0d extra_fetch=%0d, want 262 apart and 0", tf1, tv1, nf1);
        else n_pass++;
        e = sb.pop_front();
        n_total++;
        if (o_count !== 9'(e.cnt) || o_found !== e.found || o_x !== 4'(e.x) || o_y !== 4'(e.y))
            $display("FAIL b2b_first_result: got count=%0d found=%b x=%0d y=%0d, want count=%0d found=%b x=%0d y=%0d",
                     o_count, o_found, o_x, o_y, e.cnt, e.found, e.x, e.y);
        else n_pass++;
        wait_fetch(tf2);
        n_total++;
        if (tf2 < 0 || tf2 - tv1 != 2)
            $display("FAIL b2b_refetch: got fetch@%0d after valid@%0d, want 2 cycles later", tf2, tv1);
        else n_pass++;
        @(negedge clk);
        en = 1'b0;
        wait_valid(tv2, nf2);
        n_total++;
        if (tv2 < 0 || tv2 - tf2 != 262 || nf2 != 0)
            $display("FAIL b2b_second: got fetch@%0d valid@%0d extra_fetch=%0d, want 262 apart and 0", tf2, tv2, nf2);
        else n_pass++;
        e = sb.pop_front();
        n_total++;
        if (o_count !== 9'(e.cnt) || o_found !== e.found || o_x !== 4'(e.x) || o_y !== 4'(e.y))
            $display("FAIL b2b_second_result: got count=%0d found=%b x=%0d y=%0d, want count=%0d found=%b x=%0d y=%0d",
                     o_count, o_found, o_x, o_y, e.cnt, e.found, e.x, e.y);
        else n_pass++;
        nf3 = 0;
        repeat (30) begin
            @(negedge clk);
            if (o_fetch === 1'b1) nf3++;
        end
        n_total++;
        if (nf3 !== 0) $display("FAIL park_idle: got %0d fetch pulses with enable low, want 0", nf3);
        else n_pass++;
    endtask

    task automatic test_reset_abort;
        int tf, tv, nf, tf2, tv2, bad;
        exp_t e;
        setup_scenario(0);
        en = 1'b1; ok = 1'b1;
        wait_fetch(tf);
        while (cyc < tf + 100) @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if ({o_fetch, o_valid, o_found, o_count, o_x, o_y} !== 20'd0)
            $display("FAIL abort_outputs: got fetch=%b valid=%b found=%b count=%0d x=%0d y=%0d, want all 0",
                     o_fetch, o_valid, o_found, o_count, o_x, o_y);
        else n_pass++;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_fetch !== 1'b0 || o_valid !== 1'b0) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL reset_hold: got %0d cycles with fetch/valid during reset, want 0", bad);
        else n_pass++;
        rst = 1'b0;
        wait_fetch(tf2);
        wait_valid(tv2, nf);
        tv = tv2;
        n_total++;
        if (tf2 < 0 || tv < 0 || tv - tf2 != 262 || nf != 0)
            $display("FAIL abort_refetch: got fetch@%0d valid@%0d extra_fetch=%0d, want 262 apart and 0", tf2, tv, nf);
        else n_pass++;
        en = 1'b0;
        e = sb.pop_front();
        n_total++;
        if (o_count !== 9'(e.cnt) || o_found !== e.found || o_x !== 4'(e.x) || o_y !== 4'(e.y))
            $display("FAIL abort_result: got count=%0d found=%b x=%0d y=%0d, want count=%0d found=%b x=%0d y=%0d",
                     o_count, o_found, o_x, o_y, e.cnt, e.found, e.x, e.y);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
